// File: rtl/mux_scan_capture.sv
// Walks a 16:1 mux through all select codes and assembles the sampled bits into a held word.
// Optional even-parity output of the held word is enabled by defining MUX_SCAN_PARITY_EN.
module mux_scan_capture #(
   parameter int unsigned SETTLE = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        w,
   output logic        s3,
   output logic        s2,
   output logic        s1,
   output logic        s0,
   output logic        busy,
   output logic        done,
   output logic [15:0] data
`ifdef MUX_SCAN_PARITY_EN
   ,
   output logic        parity
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  sel_q, sel_d;
   logic [15:0] sr_q, sr_d;
   logic [15:0] data_q, data_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
`ifdef MUX_SCAN_PARITY_EN
   logic        parity_q, parity_d;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sel_d    = sel_q;
      sr_d     = sr_q;
      data_d   = data_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      parity_d = parity_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            sel_d  = '0;
            busy_d = 1'b0;
            if (start) begin
               state_d = ST_SETTLE;
               cnt_d   = '0;
               sr_d    = '0;
               busy_d  = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_SAMPLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_SAMPLE: begin
            sr_d = {sr_q[14:0], w};
            // The select advance and the sample share an edge, so the next code gets a full settle window.
            if (sel_q == 4'd15) begin
               state_d  = ST_DONE;
               data_d   = {sr_q[14:0], w};
               busy_d   = 1'b0;
               done_d   = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
               parity_d = ^{sr_q[14:0], w};
`endif
            end else begin
               sel_d   = sel_q + 4'd1;
               state_d = ST_SETTLE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            sel_d   = '0;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         sel_q    <= '0;
         sr_q     <= '0;
         data_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         sr_q     <= sr_d;
         data_q   <= data_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef MUX_SCAN_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign {s3, s2, s1, s0} = sel_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign data             = data_q;
`ifdef MUX_SCAN_PARITY_EN
   assign parity           = parity_q;
`endif

endmodule

// File: doc/mux_scan_capture.md
# mux_scan_capture

Sequential capture stage that sits directly downstream of the 16:1 mux. It drives the mux select lines through all 16 codes, waits a programmable settle time on each, samples the mux output and assembles the original 16-bit input word. It has a start/done handshake and a held result register, so the rest of the design reads a parallel word instead of walking the mux by hand.

## Interface
- SETTLE, 10, cycles to wait after each select change before sampling; legal range 1..15. The default covers the two-level mux delay of 90 ns worst case at a 10 ns clock.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request one scan; sampled only in IDLE
- w  in  1  mux output
- s3, s2, s1, s0  out  1 each  mux select; {s3,s2,s1,s0} = sel[3:0]
- busy  out  1  high from the start-accept edge until DONE is entered
- done  out  1  one-cycle pulse; data is valid and updated
- data  out  16  last captured word, held between scans
- parity  out  1  even parity of data (only with MUX_SCAN_PARITY_EN)

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - sel = 0, busy = 0, done = 0.
  - start = 1 → SETTLE, with sel = 0, settle counter cnt = 0, shift register sr = 0.
- SETTLE:
  - cnt increments each cycle.
  - When cnt == SETTLE-1 → SAMPLE; cnt clears.
- SAMPLE:
  - sr <= {sr[14:0], w}.
  - If sel == 15 → DONE, and data <= {sr[14:0], w} at the same edge.
  - Otherwise sel <= sel+1 → SETTLE.
- DONE:
  - done = 1 for exactly one cycle, busy = 0.
  - Next state IDLE, with sel = 0.
- Mapping: select code k routes mux input d[15-k]. Scanning k = 0..15 with a left shift therefore yields data == d, with data[15] sampled first.
- start while busy or in DONE is ignored; it is not queued.
- data and parity change only on the edge entering DONE, and hold through later scans until that scan's DONE edge.
- sel wraps only via the DONE → IDLE return. It never increments past 15.
- Reset asserted mid-scan: the next edge forces IDLE and clears sel, cnt, sr, data, parity, busy and done. The partial word is discarded. There is no done pulse for the aborted scan.
- start and rst high together: reset wins.

## Timing
- All outputs are registered. Reset values:
  - sel = 0, busy = 0, done = 0, data = 16'h0000, parity = 0.
- Start accepted at edge E0 (start = 1 in IDLE):
  - busy is high after E0.
  - sel = 0 is already stable, because IDLE holds 0.
- Bit k (k = 0..15) is sampled at edge E0 + (k+1)(SETTLE+1).
- sel changes to k+1 on the same edge that samples bit k, giving a full SETTLE cycles of settle time before the next sample.
- data updates and done rises at edge E0 + 16(SETTLE+1):
  - 176 cycles for SETTLE = 10.
  - done falls one edge later.
- busy falls on the same edge that done rises.
- Earliest next start accepted: edge E0 + 16(SETTLE+1) + 2, i.e. the first edge in IDLE.
- Throughput: one word per 16(SETTLE+1) + 2 cycles.
- Requirement: SETTLE × Tclk > mux worst-case delay (90 ns). This is a system constraint and is not checked by the block.

## Configuration
- MUX_SCAN_PARITY_EN
  - Defined: the parity port exists. It is a register equal to ^data, loaded on the same edge as data and reset to 0.
  - Undefined: the parity port and its register are absent; all other behaviour is identical.

## Test plan
- Reset then idle: rst high for 2 cycles → sel = 0, busy = 0, done = 0, data = 16'h0000, parity = 0; outputs hold with start = 0.
- Basic capture: mux d = 16'hA5C3, SETTLE = 10, 10 ns clock, pulse start → done pulses exactly 176 edges after accept and data = 16'hA5C3; parity = 0 when MUX_SCAN_PARITY_EN is defined.
- Back-to-back scans:
  - d = 16'h0001 for the first scan → data = 16'h0001.
  - d = 16'h8000 for the second, with start held high throughout → the second start is accepted at the first IDLE edge and data = 16'h8000.
  - During the second scan, data holds 16'h0001 until done.
- start ignored while busy: pulse start again at sel = 7 → no restart, sel continues 8..15, exactly one done pulse.
- Reset mid-scan: assert rst at sel = 9 → the next edge gives IDLE, data = 16'h0000, no done. A subsequent scan of d = 16'hFFFF gives data = 16'hFFFF and parity = 0.
- Select sequence: record sel at each SAMPLE edge → 0,1,…,15 in order, each held for exactly SETTLE+1 cycles. The w value sampled at code k equals d[15-k].
